instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 74 +++++++
 rtl/instr_encoder_field_pack.sv | 101 ++++++++++
 rtl/instr_encoder.sv | 111 +++++++++++
 tb/tb_instr_encoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: mnemonic codes, MIPS32
// opcode/funct constants, instruction formats and encoder FSM states.
package instr_encoder_pkg;

  typedef enum logic [5:0] {
    OP_ADD   = 6'd0,  OP_ADDU  = 6'd1,  OP_SUB   = 6'd2,  OP_AND   = 6'd3,
    OP_OR    = 6'd4,  OP_NOR   = 6'd5,  OP_XOR   = 6'd6,  OP_SLT   = 6'd7,
    OP_SLTU  = 6'd8,  OP_SLL   = 6'd9,  OP_SRL   = 6'd10, OP_ROTR  = 6'd11,
    OP_SLLV  = 6'd12, OP_SRLV  = 6'd13, OP_ROTRV = 6'd14, OP_JR    = 6'd15,
    OP_MUL   = 6'd16, OP_LW    = 6'd17, OP_LH    = 6'd18, OP_LB    = 6'd19,
    OP_SW    = 6'd20, OP_SH    = 6'd21, OP_SB    = 6'd22, OP_LUI   = 6'd23,
    OP_ADDI  = 6'd24, OP_ADDIU = 6'd25, OP_ANDI  = 6'd26, OP_ORI   = 6'd27,
    OP_XORI  = 6'd28, OP_SLTI  = 6'd29, OP_SLTIU = 6'd30, OP_BEQ   = 6'd31,
    OP_BNE   = 6'd32, OP_BGTZ  = 6'd33, OP_BLEZ  = 6'd34, OP_BGEZ  = 6'd35,
    OP_BLTZ  = 6'd36, OP_J     = 6'd37, OP_JAL   = 6'd38, OP_SEB   = 6'd39,
    OP_SEH   = 6'd40
  } op_e;

  localparam logic [5:0] OPC_SPECIAL  = 6'h00;
  localparam logic [5:0] OPC_REGIMM   = 6'h01;
  localparam logic [5:0] OPC_J        = 6'h02;
  localparam logic [5:0] OPC_JAL      = 6'h03;
  localparam logic [5:0] OPC_BEQ      = 6'h04;
  localparam logic [5:0] OPC_BNE      = 6'h05;
  localparam logic [5:0] OPC_BLEZ     = 6'h06;
  localparam logic [5:0] OPC_BGTZ     = 6'h07;
  localparam logic [5:0] OPC_ADDI     = 6'h08;
  localparam logic [5:0] OPC_ADDIU    = 6'h09;
  localparam logic [5:0] OPC_SLTI     = 6'h0A;
  localparam logic [5:0] OPC_SLTIU    = 6'h0B;
  localparam logic [5:0] OPC_ANDI     = 6'h0C;
  localparam logic [5:0] OPC_ORI      = 6'h0D;
  localparam logic [5:0] OPC_XORI     = 6'h0E;
  localparam logic [5:0] OPC_LUI      = 6'h0F;
  localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OPC_SPECIAL3 = 6'h1F;
  localparam logic [5:0] OPC_LB       = 6'h20;
  localparam logic [5:0] OPC_LH       = 6'h21;
  localparam logic [5:0] OPC_LW       = 6'h23;
  localparam logic [5:0] OPC_SB       = 6'h28;
  localparam logic [5:0] OPC_SH       = 6'h29;
  localparam logic [5:0] OPC_SW       = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;
  localparam logic [5:0] F_MUL   = 6'h02;
  localparam logic [5:0] F_BSHFL = 6'h20;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;
  localparam logic [4:0] SA_SEB  = 5'b10000;
  localparam logic [4:0] SA_SEH  = 5'b11000;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_J, FMT_REGIMM, FMT_SPECIAL3
  } fmt_e;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_WRITE, S_FULL, S_ERR
  } state_e;

endpackage

// File: rtl/instr_encoder_field_pack.sv
// Combinational mnemonic-to-MIPS32 word packer; fields an instruction does
// not use are forced to zero or to their fixed special value.
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        supported
);

  fmt_e       fmt;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       use_rs, use_rt, use_rd, use_sh;
  logic [4:0] rs_fix, rt_fix, sh_fix;
  logic [4:0] rs_f, rt_f, rd_f, sh_f;

  always_comb begin
    supported = 1'b1;
    fmt       = FMT_R;
    opcode    = OPC_SPECIAL;
    funct     = 6'd0;
    use_rs    = 1'b1;
    use_rt    = 1'b1;
    use_rd    = 1'b1;
    use_sh    = 1'b0;
    rs_fix    = 5'd0;
    rt_fix    = 5'd0;
    sh_fix    = 5'd0;
    case (op)
      OP_ADD:   funct = F_ADD;
      OP_ADDU:  funct = F_ADDU;
      OP_SUB:   funct = F_SUB;
      OP_AND:   funct = F_AND;
      OP_OR:    funct = F_OR;
      OP_NOR:   funct = F_NOR;
      OP_XOR:   funct = F_XOR;
      OP_SLT:   funct = F_SLT;
      OP_SLTU:  funct = F_SLTU;
      OP_SLL:   begin use_rs = 1'b0; use_sh = 1'b1; funct = F_SLL; end
      OP_SRL:   begin use_rs = 1'b0; use_sh = 1'b1; funct = F_SRL; end
      // rotate shares srl's funct and is told apart by the R bit (bit 21 / bit 6)
      OP_ROTR:  begin use_rs = 1'b0; rs_fix = 5'd1; use_sh = 1'b1; funct = F_SRL; end
      OP_SLLV:  funct = F_SLLV;
      OP_SRLV:  funct = F_SRLV;
      OP_ROTRV: begin sh_fix = 5'd1; funct = F_SRLV; end
      OP_JR:    begin use_rt = 1'b0; use_rd = 1'b0; funct = F_JR; end
      OP_MUL:   begin opcode = OPC_SPECIAL2; funct = F_MUL; end
      OP_LW:    begin fmt = FMT_I; opcode = OPC_LW; end
      OP_LH:    begin fmt = FMT_I; opcode = OPC_LH; end
      OP_LB:    begin fmt = FMT_I; opcode = OPC_LB; end
      OP_SW:    begin fmt = FMT_I; opcode = OPC_SW; end
      OP_SH:    begin fmt = FMT_I; opcode = OPC_SH; end
      OP_SB:    begin fmt = FMT_I; opcode = OPC_SB; end
      OP_LUI:   begin fmt = FMT_I; opcode = OPC_LUI; use_rs = 1'b0; end
      OP_ADDI:  begin fmt = FMT_I; opcode = OPC_ADDI; end
      OP_ADDIU: begin fmt = FMT_I; opcode = OPC_ADDIU; end
      OP_ANDI:  begin fmt = FMT_I; opcode = OPC_ANDI; end
      OP_ORI:   begin fmt = FMT_I; opcode = OPC_ORI; end
      OP_XORI:  begin fmt = FMT_I; opcode = OPC_XORI; end
      OP_SLTI:  begin fmt = FMT_I; opcode = OPC_SLTI; end
      OP_SLTIU: begin fmt = FMT_I; opcode = OPC_SLTIU; end
      OP_BEQ:   begin fmt = FMT_I; opcode = OPC_BEQ; end
      OP_BNE:   begin fmt = FMT_I; opcode = OPC_BNE; end
      OP_BGTZ:  begin fmt = FMT_I; opcode = OPC_BGTZ; use_rt = 1'b0; end
      OP_BLEZ:  begin fmt = FMT_I; opcode = OPC_BLEZ; use_rt = 1'b0; end
      OP_BGEZ:  begin fmt = FMT_REGIMM; use_rt = 1'b0; rt_fix = RT_BGEZ; end
      OP_BLTZ:  begin fmt = FMT_REGIMM; use_rt = 1'b0; rt_fix = RT_BLTZ; end
      OP_J:     begin fmt = FMT_J; opcode = OPC_J; end
      OP_JAL:   begin fmt = FMT_J; opcode = OPC_JAL; end
      OP_SEB:   begin fmt = FMT_SPECIAL3; use_rs = 1'b0; sh_fix = SA_SEB; end
      OP_SEH:   begin fmt = FMT_SPECIAL3; use_rs = 1'b0; sh_fix = SA_SEH; end
      default:  supported = 1'b0;
    endcase
  end

  assign rs_f = use_rs ? rs    : rs_fix;
  assign rt_f = use_rt ? rt    : rt_fix;
  assign rd_f = use_rd ? rd    : 5'd0;
  assign sh_f = use_sh ? shamt : sh_fix;

  always_comb begin
    word = '0;
    if (supported) begin
      case (fmt)
        FMT_R:        word = {opcode, rs_f, rt_f, rd_f, sh_f, funct};
        FMT_I:        word = {opcode, rs_f, rt_f, imm[15:0]};
        FMT_REGIMM:   word = {OPC_REGIMM, rs_f, rt_f, imm[15:0]};
        FMT_J:        word = {opcode, imm};
        FMT_SPECIAL3: word = {OPC_SPECIAL3, rs_f, rt_f, rd_f, sh_f, F_BSHFL};
        default:      word = '0;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts descriptors, packs them into MIPS32 words and
// writes them one per two cycles into a DEPTH-word program region.
//
// state    | meaning
// S_IDLE   | waiting for Start after reset
// S_ACCEPT | InReady high, waiting for a descriptor
// S_WRITE  | MemWrite high for the registered word
// S_FULL   | DEPTH words written, waiting for Start
// S_ERR    | unsupported Op seen, sticky until Start or reset
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [31:0] BaseAddr,
  input  logic        InValid,
  output logic        InReady,
  input  logic [5:0]  Op,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic [4:0]  Shamt,
  input  logic [25:0] Imm,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWriteData,
  output logic [10:0] Count,
  output logic        Full,
  output logic        Error
);

  localparam logic [10:0] DEPTH_C = 11'(DEPTH);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic [10:0] count_q, count_d;
  logic [31:0] pack_word;
  logic        pack_ok;

  instr_field_pack u_pack (
    .op        (Op),
    .rs        (Rs),
    .rt        (Rt),
    .rd        (Rd),
    .shamt     (Shamt),
    .imm       (Imm),
    .word      (pack_word),
    .supported (pack_ok)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  // Start wins from every state, including aborting a pending write.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
    count_d  = count_q;
    InReady  = 1'b0;
    MemWrite = 1'b0;
    if (Start) begin
      state_d = S_ACCEPT;
      addr_d  = BaseAddr;
      count_d = '0;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          InReady = 1'b1;
          if (InValid) begin
            if (pack_ok) begin
              word_d  = pack_word;
              state_d = S_WRITE;
            end else begin
              state_d = S_ERR;
            end
          end
        end
        S_WRITE: begin
          MemWrite = 1'b1;
          addr_d   = addr_q + 32'd4;
          count_d  = count_q + 11'd1;
          state_d  = (count_q + 11'd1 == DEPTH_C) ? S_FULL : S_ACCEPT;
        end
        default: ;
      endcase
    end
  end

  assign MemAddr      = addr_q;
  assign MemWriteData = word_q;
  assign Count        = count_q;
  assign Full         = (state_q == S_FULL);
  assign Error        = (state_q == S_ERR);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus randomized bench for instr_encoder, with a mnemonic-level
// reference encoder built from plain shift-and-or arithmetic.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] BaseAddr = '0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [5:0]  Op = '0;
  logic [4:0]  Rs = '0, Rt = '0, Rd = '0, Shamt = '0;
  logic [25:0] Imm = '0;
  logic        MemWrite;
  logic [31:0] MemAddr, MemWriteData;
  logic [10:0] Count;
  logic        Full, Error;

  int pass_cnt = 0;
  int total_cnt = 0;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .BaseAddr(BaseAddr),
    .InValid(InValid), .InReady(InReady), .Op(Op), .Rs(Rs), .Rt(Rt),
    .Rd(Rd), .Shamt(Shamt), .Imm(Imm), .MemWrite(MemWrite),
    .MemAddr(MemAddr), .MemWriteData(MemWriteData), .Count(Count),
    .Full(Full), .Error(Error)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] opc(input int o);
    return 32'(o) << 26;
  endfunction

  // Reference encoder: each mnemonic written out from its MIPS32 definition.
  function automatic logic [31:0] model_word(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic [4:0] sh, input logic [25:0] imm);
    logic [31:0] s, t, d, a, i;
    s = 32'(rs) << 21; t = 32'(rt) << 16; d = 32'(rd) << 11;
    a = 32'(sh) << 6;  i = 32'(imm[15:0]);
    case (op)
      OP_ADD:   return s | t | d | 32'h20;
      OP_ADDU:  return s | t | d | 32'h21;
      OP_SUB:   return s | t | d | 32'h22;
      OP_AND:   return s | t | d | 32'h24;
      OP_OR:    return s | t | d | 32'h25;
      OP_XOR:   return s | t | d | 32'h26;
      OP_NOR:   return s | t | d | 32'h27;
      OP_SLT:   return s | t | d | 32'h2A;
      OP_SLTU:  return s | t | d | 32'h2B;
      OP_SLL:   return t | d | a;
      OP_SRL:   return t | d | a | 32'h02;
      OP_ROTR:  return (32'd1 << 21) | t | d | a | 32'h02;
      OP_SLLV:  return s | t | d | 32'h04;
      OP_SRLV:  return s | t | d | 32'h06;
      OP_ROTRV: return s | t | d | (32'd1 << 6) | 32'h06;
      OP_JR:    return s | 32'h08;
      OP_MUL:   return opc(28) | s | t | d | 32'h02;
      OP_LW:    return opc(35) | s | t | i;
      OP_LH:    return opc(33) | s | t | i;
      OP_LB:    return opc(32) | s | t | i;
      OP_SW:    return opc(43) | s | t | i;
      OP_SH:    return opc(41) | s | t | i;
      OP_SB:    return opc(40) | s | t | i;
      OP_LUI:   return opc(15) | t | i;
      OP_ADDI:  return opc(8)  | s | t | i;
      OP_ADDIU: return opc(9)  | s | t | i;
      OP_SLTI:  return opc(10) | s | t | i;
      OP_SLTIU: return opc(11) | s | t | i;
      OP_ANDI:  return opc(12) | s | t | i;
      OP_ORI:   return opc(13) | s | t | i;
      OP_XORI:  return opc(14) | s | t | i;
      OP_BEQ:   return opc(4)  | s | t | i;
      OP_BNE:   return opc(5)  | s | t | i;
      OP_BLEZ:  return opc(6)  | s | i;
      OP_BGTZ:  return opc(7)  | s | i;
      OP_BGEZ:  return opc(1)  | s | (32'd1 << 16) | i;
      OP_BLTZ:  return opc(1)  | s | i;
      OP_J:     return opc(2)  | 32'(imm);
      OP_JAL:   return opc(3)  | 32'(imm);
      OP_SEB:   return opc(31) | t | d | (32'd16 << 6) | 32'h20;
      OP_SEH:   return opc(31) | t | d | (32'd24 << 6) | 32'h20;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] base);
    Start = 1'b1;
    BaseAddr = base;
    step();
    Start = 1'b0;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm,
      input logic [31:0] exp_addr, input logic [10:0] exp_cnt);
    logic [31:0] exp_w;
    exp_w = model_word(op, rs, rt, rd, sh, imm);
    Op = op; Rs = rs; Rt = rt; Rd = rd; Shamt = sh; Imm = imm;
    InValid = 1'b1;
    #1;
    check("in_ready_accept", 32'(InReady), 32'd1);
    check("no_write_accept", 32'(MemWrite), 32'd0);
    step();
    InValid = 1'b0;
    #1;
    check("mem_write", 32'(MemWrite), 32'd1);
    check("mem_addr", MemAddr, exp_addr);
    check("mem_data", MemWriteData, exp_w);
    check("in_ready_write", 32'(InReady), 32'd0);
    step();
    check("mem_write_drop", 32'(MemWrite), 32'd0);
    check("count", 32'(Count), 32'(exp_cnt));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(InReady), 32'd0);
    check({tag, "_mem_write"}, 32'(MemWrite), 32'd0);
    check({tag, "_mem_addr"}, MemAddr, 32'd0);
    check({tag, "_mem_data"}, MemWriteData, 32'd0);
    check({tag, "_count"}, 32'(Count), 32'd0);
    check({tag, "_full"}, 32'(Full), 32'd0);
    check({tag, "_error"}, 32'(Error), 32'd0);
  endtask

  initial begin
    logic [31:0] base;
    logic [5:0]  rop;

    // Reset state
    #3;
    check_reset_outputs("reset");
    step();
    Rst = 1'b1;
    step();
    check("idle_in_ready", 32'(InReady), 32'd0);

    // add $3,$1,$2 at 0x400
    do_start(32'h400);
    check("literal_add", model_word(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0), 32'h00221820);
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 32'h400, 11'd1);

    // lw $t0,4($sp) then beq, back to back
    do_start(32'h400);
    send(OP_LW, 5'd29, 5'd8, 5'd0, 5'd0, 26'd4, 32'h400, 11'd1);
    send(OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 26'hFFFF, 32'h404, 11'd2);
    check("literal_lw", model_word(OP_LW, 5'd29, 5'd8, 5'd0, 5'd0, 26'd4), 32'h8FA80004);
    check("literal_beq", model_word(OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 26'hFFFF), 32'h1022FFFF);

    // rotr and seh special fields
    do_start(32'h1000);
    send(OP_ROTR, 5'd0, 5'd5, 5'd4, 5'd2, 26'd0, 32'h1000, 11'd1);
    send(OP_SEH, 5'd0, 5'd7, 5'd6, 5'd0, 26'd0, 32'h1004, 11'd2);
    check("literal_rotr", model_word(OP_ROTR, 5'd0, 5'd5, 5'd4, 5'd2, 26'd0), 32'h00252082);
    check("literal_seh", model_word(OP_SEH, 5'd0, 5'd7, 5'd6, 5'd0, 26'd0), 32'h7C073620);

    // Fill the region: four writes then Full, fifth descriptor refused
    do_start(32'h2000);
    for (int k = 0; k < DEPTH; k++)
      send(OP_ADDIU, 5'(k), 5'(k + 1), 5'd0, 5'd0, 26'(k * 3), 32'h2000 + 32'(4 * k), 11'(k + 1));
    check("full_flag", 32'(Full), 32'd1);
    check("full_in_ready", 32'(InReady), 32'd0);
    Op = OP_ADD; InValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("full_no_write", 32'(MemWrite), 32'd0);
    end
    InValid = 1'b0;
    check("full_count_hold", 32'(Count), 32'(DEPTH));
    do_start(32'h3000);
    check("full_cleared", 32'(Full), 32'd0);
    check("full_count_cleared", 32'(Count), 32'd0);
    send(OP_OR, 5'd9, 5'd10, 5'd11, 5'd0, 26'd0, 32'h3000, 11'd1);

    // Unsupported op 63 -> sticky Error, no write; Start recovers
    Op = 6'd63; InValid = 1'b1;
    step();
    InValid = 1'b0;
    check("err_flag", 32'(Error), 32'd1);
    check("err_no_write", 32'(MemWrite), 32'd0);
    check("err_in_ready", 32'(InReady), 32'd0);
    step();
    check("err_sticky", 32'(Error), 32'd1);
    check("err_no_write2", 32'(MemWrite), 32'd0);
    do_start(32'h500);
    check("err_cleared", 32'(Error), 32'd0);
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 32'h500, 11'd1);

    // Start during WRITE aborts the pending word
    Op = OP_SUB; Rs = 5'd4; Rt = 5'd5; Rd = 5'd6; InValid = 1'b1;
    step();
    InValid = 1'b0;
    Start = 1'b1; BaseAddr = 32'h700;
    #1;
    check("abort_no_write", 32'(MemWrite), 32'd0);
    step();
    Start = 1'b0;
    check("abort_count", 32'(Count), 32'd0);
    check("abort_addr", MemAddr, 32'h700);
    send(OP_XOR, 5'd1, 5'd1, 5'd1, 5'd0, 26'd0, 32'h700, 11'd1);

    // Randomized programs, first one wrapping past 2^32
    for (int blk = 0; blk < 4; blk++) begin
      base = (blk == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      do_start(base);
      for (int k = 0; k < DEPTH; k++) begin
        rop = 6'($urandom_range(0, 40));
        send(rop, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             26'($urandom()), base + 32'(4 * k), 11'(k + 1));
      end
      check("rand_full", 32'(Full), 32'd1);
    end

    // Random unsupported op
    do_start(32'h800);
    Op = 6'($urandom_range(41, 63)); InValid = 1'b1;
    step();
    InValid = 1'b0;
    check("rand_err", 32'(Error), 32'd1);
    check("rand_err_no_write", 32'(MemWrite), 32'd0);

    // Reset pulsed mid-WRITE
    do_start(32'h900);
    Op = OP_AND; Rs = 5'd1; Rt = 5'd2; Rd = 5'd3; InValid = 1'b1;
    step();
    InValid = 1'b0;
    check("pre_reset_write", 32'(MemWrite), 32'd1);
    Rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    step();
    Rst = 1'b1;
    step();
    check("post_reset_idle", 32'(InReady), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
